// File: rtl/bp_pkg.sv
// Shared definitions for the branch predictor table.
// Counter encodings and the saturating next-state helper.
package bp_pkg;

    localparam logic [1:0] CNT_SNT = 2'b00;
    localparam logic [1:0] CNT_WNT = 2'b01;
    localparam logic [1:0] CNT_WT  = 2'b10;
    localparam logic [1:0] CNT_ST  = 2'b11;

    function automatic logic [1:0] next_counter(
        input logic [1:0] cnt,
        input logic       taken
    );
        logic [1:0] nxt;
        nxt = cnt;
        unique case (1'b1)
            taken && (cnt != CNT_ST):   nxt = cnt + 2'd1;
            !taken && (cnt != CNT_SNT): nxt = cnt - 2'd1;
            default:                    nxt = cnt;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/branch_predictor_table_if.sv
// Fetch/execute facing bundle of the branch predictor table.
// master = pipeline side, slave = predictor.
interface branch_predictor_table_if #(
    parameter int INDEX_W = 4,
    parameter int TAG_W   = 5
);
    localparam int ADDR_W = INDEX_W + TAG_W;

    logic              flush;
    logic              lookup_valid;
    logic [ADDR_W-1:0] lookup_addr;
    logic              pred_valid;
    logic              pred_hit;
    logic              pred_taken;
    logic              upd_valid;
    logic [ADDR_W-1:0] upd_addr;
    logic              upd_taken;

    modport master (
        output flush, lookup_valid, lookup_addr,
        output upd_valid, upd_addr, upd_taken,
        input  pred_valid, pred_hit, pred_taken
    );

    modport slave (
        input  flush, lookup_valid, lookup_addr,
        input  upd_valid, upd_addr, upd_taken,
        output pred_valid, pred_hit, pred_taken
    );

endinterface

// File: rtl/sat_counter_2b.sv
// Combinational next state of a 2-bit saturating counter.
module sat_counter_2b
    import bp_pkg::*;
(
    input  logic [1:0] cnt,
    input  logic       taken,
    output logic [1:0] nxt
);

    assign nxt = next_counter(cnt, taken);

endmodule

// File: rtl/branch_predictor_table.sv
// Direct-mapped branch history table with registered prediction,
// execute-stage training and write-first lookup forwarding.
module branch_predictor_table
    import bp_pkg::*;
#(
    parameter int INDEX_W = 4,
    parameter int TAG_W   = 5
) (
    input  logic                     clk,
    input  logic                     reset,
    branch_predictor_table_if.slave  bus
);

    localparam int ADDR_W = INDEX_W + TAG_W;
    localparam int DEPTH  = 1 << INDEX_W;

    logic             valid_q [DEPTH];
    logic [TAG_W-1:0] tag_q   [DEPTH];
    logic [1:0]       cnt_q   [DEPTH];

    logic [INDEX_W-1:0] u_idx;
    logic [TAG_W-1:0]   u_tag;
    logic               u_hit;
    logic [1:0]         u_inc;
    logic [1:0]         u_cnt;

    logic [INDEX_W-1:0] l_idx;
    logic [TAG_W-1:0]   l_tag;
    logic               fwd;
    logic               e_valid;
    logic [TAG_W-1:0]   e_tag;
    logic [1:0]         e_cnt;
    logic               l_hit;

    assign u_idx = bus.upd_addr[INDEX_W-1:0];
    assign u_tag = bus.upd_addr[ADDR_W-1:INDEX_W];
    assign l_idx = bus.lookup_addr[INDEX_W-1:0];
    assign l_tag = bus.lookup_addr[ADDR_W-1:INDEX_W];

    // A flush clears valids before the update, so it always allocates.
    assign u_hit = !bus.flush && valid_q[u_idx]
                   && (tag_q[u_idx] == u_tag);

    sat_counter_2b u_sat (
        .cnt   (cnt_q[u_idx]),
        .taken (bus.upd_taken),
        .nxt   (u_inc)
    );

    assign u_cnt = u_hit ? u_inc
                 : (bus.upd_taken ? CNT_WT : CNT_WNT);

    always_comb begin
        fwd     = bus.upd_valid && (u_idx == l_idx);
        e_valid = valid_q[l_idx];
        e_tag   = tag_q[l_idx];
        e_cnt   = cnt_q[l_idx];
        if (fwd) begin
            e_valid = 1'b1;
            e_tag   = u_tag;
            e_cnt   = u_cnt;
        end
        l_hit = !bus.flush && e_valid && (e_tag == l_tag);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                valid_q[i] <= 1'b0;
                tag_q[i]   <= '0;
                cnt_q[i]   <= CNT_WNT;
            end
            bus.pred_valid <= 1'b0;
            bus.pred_hit   <= 1'b0;
            bus.pred_taken <= 1'b0;
        end else begin
            if (bus.flush) begin
                for (int i = 0; i < DEPTH; i++) begin
                    valid_q[i] <= 1'b0;
                end
            end
            if (bus.upd_valid) begin
                valid_q[u_idx] <= 1'b1;
                tag_q[u_idx]   <= u_tag;
                cnt_q[u_idx]   <= u_cnt;
            end
            bus.pred_valid <= bus.lookup_valid;
            bus.pred_hit   <= bus.lookup_valid && l_hit;
            bus.pred_taken <= bus.lookup_valid && l_hit && e_cnt[1];
        end
    end

endmodule

// File: tb/tb_branch_predictor_table.sv
// Directed vector table plus randomized run against a table model.
module tb_branch_predictor_table;

    localparam int INDEX_W = 4;
    localparam int TAG_W   = 5;
    localparam int DEPTH   = 16;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    branch_predictor_table_if #(.INDEX_W(INDEX_W), .TAG_W(TAG_W)) bus ();

    branch_predictor_table #(.INDEX_W(INDEX_W), .TAG_W(TAG_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    typedef struct {
        logic       flush;
        logic       lv;
        logic [8:0] la;
        logic       uv;
        logic [8:0] ua;
        logic       ut;
        logic       pv;
        logic       hit;
        logic       tk;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    // Reference table: counter kept as an integer 0..3.
    bit       m_valid [DEPTH];
    int       m_tag   [DEPTH];
    int       m_cnt   [DEPTH];

    task automatic addv(input logic fl, input logic lv, input logic [8:0] la,
                        input logic uv, input logic [8:0] ua, input logic ut,
                        input logic pv, input logic hit, input logic tk);
        vec_t v;
        v.flush = fl; v.lv = lv; v.la = la;
        v.uv = uv; v.ua = ua; v.ut = ut;
        v.pv = pv; v.hit = hit; v.tk = tk;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic fl, input logic lv, input logic [8:0] la,
                         input logic uv, input logic [8:0] ua, input logic ut);
        bus.flush        = fl;
        bus.lookup_valid = lv;
        bus.lookup_addr  = la;
        bus.upd_valid    = uv;
        bus.upd_addr     = ua;
        bus.upd_taken    = ut;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) begin
            m_valid[i] = 0;
            m_tag[i]   = 0;
            m_cnt[i]   = 1;
        end
    endtask

    initial begin
        int idx;
        int tg;
        logic fl, lv, uv, ut;
        logic [8:0] la, ua;
        logic e_pv, e_hit, e_tk;

        // 1: cold miss
        addv(0, 1, 9'h0A3, 0, 0, 0, 1, 0, 0);
        // 2: allocate taken, then saturate up
        addv(0, 0, 0, 1, 9'h0A3, 1, 0, 0, 0);
        addv(0, 1, 9'h0A3, 0, 0, 0, 1, 1, 1);
        addv(0, 0, 0, 1, 9'h0A3, 1, 0, 0, 0);
        addv(0, 1, 9'h0A3, 0, 0, 0, 1, 1, 1);
        addv(0, 0, 0, 1, 9'h0A3, 1, 0, 0, 0);
        addv(0, 1, 9'h0A3, 0, 0, 0, 1, 1, 1);
        // 3: walk down to 00 and hold
        addv(0, 0, 0, 1, 9'h0A3, 0, 0, 0, 0);
        addv(0, 1, 9'h0A3, 0, 0, 0, 1, 1, 1);
        addv(0, 0, 0, 1, 9'h0A3, 0, 0, 0, 0);
        addv(0, 1, 9'h0A3, 0, 0, 0, 1, 1, 0);
        addv(0, 0, 0, 1, 9'h0A3, 0, 0, 0, 0);
        addv(0, 1, 9'h0A3, 0, 0, 0, 1, 1, 0);
        addv(0, 0, 0, 1, 9'h0A3, 0, 0, 0, 0);
        addv(0, 1, 9'h0A3, 0, 0, 0, 1, 1, 0);
        addv(0, 0, 0, 1, 9'h0A3, 1, 0, 0, 0);
        addv(0, 1, 9'h0A3, 0, 0, 0, 1, 1, 0);
        // 4: climb to 11, then replace with a new tag
        addv(0, 0, 0, 1, 9'h0A3, 1, 0, 0, 0);
        addv(0, 0, 0, 1, 9'h0A3, 1, 0, 0, 0);
        addv(0, 1, 9'h0A3, 0, 0, 0, 1, 1, 1);
        addv(0, 0, 0, 1, 9'h1E3, 0, 0, 0, 0);
        addv(0, 1, 9'h0A3, 0, 0, 0, 1, 0, 0);
        addv(0, 1, 9'h1E3, 0, 0, 0, 1, 1, 0);
        // 5: same-cycle forwarding on a miss allocation
        addv(0, 1, 9'h045, 1, 9'h045, 1, 1, 1, 1);
        // 6: flush with a same-cycle update
        addv(0, 0, 0, 1, 9'h0A3, 1, 0, 0, 0);
        addv(1, 1, 9'h0A3, 1, 9'h012, 1, 1, 0, 0);
        addv(0, 1, 9'h0A3, 0, 0, 0, 1, 0, 0);
        addv(0, 1, 9'h012, 0, 0, 0, 1, 1, 1);
        addv(0, 1, 9'h045, 0, 0, 0, 1, 0, 0);

        do_reset();
        check("reset_pred_valid", bus.pred_valid, 1'b0);
        check("reset_pred_hit", bus.pred_hit, 1'b0);
        check("reset_pred_taken", bus.pred_taken, 1'b0);

        foreach (vecs[i]) begin
            drive(vecs[i].flush, vecs[i].lv, vecs[i].la,
                  vecs[i].uv, vecs[i].ua, vecs[i].ut);
            step();
            check($sformatf("vec%0d_pred_valid", i), bus.pred_valid, vecs[i].pv);
            check($sformatf("vec%0d_pred_hit", i), bus.pred_hit, vecs[i].hit);
            check($sformatf("vec%0d_pred_taken", i), bus.pred_taken, vecs[i].tk);
        end

        // Mid-stream reset overrides lookup and update
        reset = 1'b1;
        drive(0, 1, 9'h012, 1, 9'h012, 1);
        step();
        check("midreset_pred_valid", bus.pred_valid, 1'b0);
        check("midreset_pred_hit", bus.pred_hit, 1'b0);
        check("midreset_pred_taken", bus.pred_taken, 1'b0);
        reset = 1'b0;
        drive(0, 1, 9'h012, 0, 0, 0);
        step();
        check("postreset_pred_valid", bus.pred_valid, 1'b1);
        check("postreset_pred_hit", bus.pred_hit, 1'b0);

        // Randomized run against the model
        do_reset();
        model_reset();
        for (int n = 0; n < 600; n++) begin
            fl = ($urandom_range(0, 31) == 0);
            lv = ($urandom_range(0, 3) != 0);
            uv = ($urandom_range(0, 2) != 0);
            ut = $urandom_range(0, 1);
            la = {5'($urandom_range(0, 2)), 4'($urandom_range(0, 15))};
            ua = {5'($urandom_range(0, 2)), 4'($urandom_range(0, 15))};
            drive(fl, lv, la, uv, ua, ut);

            if (fl) begin
                for (int i = 0; i < DEPTH; i++) m_valid[i] = 0;
            end
            if (uv) begin
                idx = int'(ua[3:0]);
                tg  = int'(ua[8:4]);
                if (m_valid[idx] && m_tag[idx] == tg) begin
                    if (ut) m_cnt[idx] = (m_cnt[idx] < 3) ? m_cnt[idx] + 1 : 3;
                    else    m_cnt[idx] = (m_cnt[idx] > 0) ? m_cnt[idx] - 1 : 0;
                end else begin
                    m_valid[idx] = 1;
                    m_tag[idx]   = tg;
                    m_cnt[idx]   = ut ? 2 : 1;
                end
            end
            idx   = int'(la[3:0]);
            tg    = int'(la[8:4]);
            e_pv  = lv;
            e_hit = lv && !fl && m_valid[idx] && (m_tag[idx] == tg);
            e_tk  = e_hit && (m_cnt[idx] >= 2);

            step();
            check("rand_pred_valid", bus.pred_valid, e_pv);
            check("rand_pred_hit", bus.pred_hit, e_hit);
            check("rand_pred_taken", bus.pred_taken, e_tk);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
